simon_seq_gen: RTL and testbench

- Parametrised successor to the Simon Says idle-state sequence loader.
- Owns its own LFSR and writes a pseudo-random colour sequence into the pattern memory.
- Two fill modes:
  - Full fill of INIT_LEN entries, for a new game.
  - Single-entry append, for each new round.
- Tracks the current sequence length, flags memory-full, and signals completion to the game FSM with a one-cycle pulse.

---
 rtl/simon_pkg.sv | 15 +
 rtl/simon_seq_gen_if.sv | 34 +++
 rtl/simon_lfsr.sv | 39 +++
 rtl/simon_seq_gen.sv | 160 ++++++++++++++++
 tb/tb_simon_seq_gen.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/simon_pkg.sv
// Shared types and defaults for the Simon Says sequence generator.
package simon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_APPEND = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int         DEF_COL_W  = 2;
    localparam int         DEF_LFSR_W = 8;
    localparam logic [7:0] DEF_TAPS   = 8'hB8;

endpackage

// File: rtl/simon_seq_gen_if.sv
// Request/status and pattern-memory write bus between the game FSM and the
// sequence generator. The game side is the master, the generator the slave.
interface simon_seq_gen_if #(
    parameter int AW     = 6,
    parameter int COL_W  = 2,
    parameter int LFSR_W = 8
);
    logic              seed_load;
    logic [LFSR_W-1:0] seed;
    logic              start;
    logic              append;

    logic              mem_wr_en;
    logic [AW-1:0]     mem_wr_addr;
    logic [COL_W-1:0]  mem_wr_data;

    logic              busy;
    logic              done;
    logic              err;
    logic [AW-1:0]     seq_len;
    logic              full;

    modport master (
        output seed_load, seed, start, append,
        input  mem_wr_en, mem_wr_addr, mem_wr_data,
        input  busy, done, err, seq_len, full
    );

    modport slave (
        input  seed_load, seed, start, append,
        output mem_wr_en, mem_wr_addr, mem_wr_data,
        output busy, done, err, seq_len, full
    );
endinterface

// File: rtl/simon_lfsr.sv
// Fibonacci-style shift-left LFSR with loadable seed; a zero seed is forced
// to 1 so the register can never lock up in the all-zero state.
module simon_lfsr #(
    parameter int                LFSR_W = 8,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(8'hB8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              step,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    // Next value: load wins over step, otherwise hold.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = (seed == '0) ? LFSR_W'(1) : seed;
        end else if (step) begin
            lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
        end
    end

    // State register with synchronous reset to 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_W'(1);
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/simon_seq_gen.sv
// Simon Says sequence generator: writes pseudo-random colours into the
// pattern memory, either a full INIT_LEN fill or a single append.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   IDLE      | waiting for seed_load / start / append
//   FILL      | one write presented per cycle until INIT_LEN are done
//   APPEND    | single write at address seq_len
//   DONE      | one-cycle done pulse (err too if append was rejected)
module simon_seq_gen
    import simon_pkg::*;
#(
    parameter int                DEPTH    = 32,
    parameter int                COL_W    = DEF_COL_W,
    parameter int                LFSR_W   = DEF_LFSR_W,
    parameter logic [LFSR_W-1:0] TAPS     = LFSR_W'(DEF_TAPS),
    parameter int                INIT_LEN = 4,
    parameter int                AW       = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    simon_seq_gen_if.slave bus
);

    state_e            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     seq_len_q, seq_len_d;
    logic              wr_en_q, wr_en_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [COL_W-1:0]  data_q, data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_nxt;
    logic              lfsr_load;
    logic              full;
    logic [AW-1:0]     seq_len_inc;
    logic              unused_lfsr_bits;

    // The LFSR advances at the edge that retires a write, so a write issued
    // back-to-back in FILL takes its colour from the post-step value.
    assign lfsr_nxt         = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
    assign unused_lfsr_bits = ^{lfsr_nxt, lfsr_q};
    assign lfsr_load        = bus.seed_load && (state_q == ST_IDLE);
    assign full             = (seq_len_q == AW'(DEPTH));
    assign seq_len_inc      = full ? seq_len_q : seq_len_q + AW'(1);

    simon_lfsr #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .seed (bus.seed),
        .step (wr_en_q),
        .q    (lfsr_q)
    );

    // Next-state and next-output decode; all outputs come from registers.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        seq_len_d = seq_len_q;
        wr_en_d   = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.seed_load) begin
                    // seed load consumes the cycle; start/append are dropped
                end else if (bus.start) begin
                    state_d   = ST_FILL;
                    wr_en_d   = 1'b1;
                    busy_d    = 1'b1;
                    addr_d    = '0;
                    data_d    = lfsr_q[COL_W-1:0];
                    cnt_d     = AW'(1);
                    seq_len_d = '0;
                end else if (bus.append) begin
                    if (!full) begin
                        state_d = ST_APPEND;
                        wr_en_d = 1'b1;
                        busy_d  = 1'b1;
                        addr_d  = seq_len_q;
                        data_d  = lfsr_q[COL_W-1:0];
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_FILL: begin
                seq_len_d = seq_len_inc;
                if (cnt_q == AW'(INIT_LEN)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    wr_en_d = 1'b1;
                    busy_d  = 1'b1;
                    addr_d  = cnt_q;
                    data_d  = lfsr_nxt[COL_W-1:0];
                    cnt_d   = cnt_q + AW'(1);
                end
            end
            ST_APPEND: begin
                seq_len_d = seq_len_inc;
                state_d   = ST_DONE;
                done_d    = 1'b1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register state and outputs; reset abandons any fill in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            seq_len_q <= '0;
            wr_en_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            seq_len_q <= seq_len_d;
            wr_en_q   <= wr_en_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.mem_wr_en   = wr_en_q;
    assign bus.mem_wr_addr = addr_q;
    assign bus.mem_wr_data = data_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.seq_len     = seq_len_q;
    assign bus.full        = full;

endmodule

// File: tb/tb_simon_seq_gen.sv
// Directed bench for simon_seq_gen: fills, appends up to full, rejected
// append, ignored mid-fill requests, reset mid-fill, request priorities.
module tb_simon_seq_gen;

    localparam int AW = 6;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [7:0] m_lfsr;

    always #5 clk = ~clk;

    simon_seq_gen_if #(.AW(AW), .COL_W(2), .LFSR_W(8)) bus ();

    simon_seq_gen #(
        .DEPTH    (32),
        .COL_W    (2),
        .LFSR_W   (8),
        .TAPS     (8'hB8),
        .INIT_LEN (4),
        .AW       (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [7:0] m_step(input logic [7:0] v);
        return {v[6:0], ^(v & 8'hB8)};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs;
        bus.seed_load = 1'b0;
        bus.seed      = 8'h00;
        bus.start     = 1'b0;
        bus.append    = 1'b0;
    endtask

    // Called right after the edge that sampled start; exp = {d3,d2,d1,d0}.
    task automatic run_fill(input string tag, input logic [7:0] exp);
        logic [1:0] d;
        for (int i = 0; i < 4; i++) begin
            d = exp[2*i +: 2];
            chk_b({tag, "_wr_en"}, bus.mem_wr_en, 1'b1);
            chk_b({tag, "_busy"}, bus.busy, 1'b1);
            chk_a({tag, "_addr"}, bus.mem_wr_addr, AW'(i));
            chk_d({tag, "_data"}, bus.mem_wr_data, d);
            chk_b({tag, "_done_early"}, bus.done, 1'b0);
            tick();
        end
        chk_b({tag, "_wr_en_end"}, bus.mem_wr_en, 1'b0);
        chk_b({tag, "_busy_end"}, bus.busy, 1'b0);
        chk_b({tag, "_done"}, bus.done, 1'b1);
        chk_b({tag, "_err"}, bus.err, 1'b0);
        chk_a({tag, "_seq_len"}, bus.seq_len, 6'd4);
        tick();
        chk_b({tag, "_done_pulse"}, bus.done, 1'b0);
    endtask

    task automatic do_append(input string tag, input logic [AW-1:0] addr, input logic [1:0] data);
        bus.append = 1'b1;
        tick();
        bus.append = 1'b0;
        chk_b({tag, "_wr_en"}, bus.mem_wr_en, 1'b1);
        chk_b({tag, "_busy"}, bus.busy, 1'b1);
        chk_a({tag, "_addr"}, bus.mem_wr_addr, addr);
        chk_d({tag, "_data"}, bus.mem_wr_data, data);
        chk_b({tag, "_done_early"}, bus.done, 1'b0);
        tick();
        chk_b({tag, "_wr_en_end"}, bus.mem_wr_en, 1'b0);
        chk_b({tag, "_done"}, bus.done, 1'b1);
        chk_b({tag, "_err"}, bus.err, 1'b0);
        chk_a({tag, "_seq_len"}, bus.seq_len, addr + 6'd1);
        tick();
        chk_b({tag, "_done_pulse"}, bus.done, 1'b0);
    endtask

    initial begin
        int done_cnt;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        chk_b("rst_wr_en", bus.mem_wr_en, 1'b0);
        chk_b("rst_busy", bus.busy, 1'b0);
        chk_b("rst_done", bus.done, 1'b0);
        chk_b("rst_err", bus.err, 1'b0);
        chk_a("rst_addr", bus.mem_wr_addr, 6'd0);
        chk_d("rst_data", bus.mem_wr_data, 2'd0);
        chk_a("rst_seq_len", bus.seq_len, 6'd0);
        chk_b("rst_full", bus.full, 1'b0);
        rst = 1'b0;

        // Zero seed becomes 1: colours 1,2,0,0 then lfsr = 8'h11.
        bus.seed_load = 1'b1;
        bus.seed      = 8'h00;
        tick();
        idle_inputs();
        chk_b("seed_busy", bus.busy, 1'b0);
        chk_b("seed_wr_en", bus.mem_wr_en, 1'b0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        run_fill("fill1", {2'd0, 2'd0, 2'd2, 2'd1});

        do_append("app1", 6'd4, 2'd1);
        m_lfsr = m_step(8'h11);
        for (int k = 5; k < 32; k++) begin
            do_append("app_n", AW'(k), m_lfsr[1:0]);
            m_lfsr = m_step(m_lfsr);
        end
        chk_a("full_seq_len", bus.seq_len, 6'd32);
        chk_b("full_flag", bus.full, 1'b1);

        // Append when full: rejected, done and err together, no write.
        bus.append = 1'b1;
        tick();
        bus.append = 1'b0;
        chk_b("rej_wr_en", bus.mem_wr_en, 1'b0);
        chk_b("rej_busy", bus.busy, 1'b0);
        chk_b("rej_done", bus.done, 1'b1);
        chk_b("rej_err", bus.err, 1'b1);
        chk_b("rej_full", bus.full, 1'b1);
        chk_a("rej_seq_len", bus.seq_len, 6'd32);
        tick();
        chk_b("rej_done_pulse", bus.done, 1'b0);
        chk_b("rej_err_pulse", bus.err, 1'b0);
        chk_a("rej_seq_len2", bus.seq_len, 6'd32);

        // Requests during FILL are ignored.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk_a("mid_addr0", bus.mem_wr_addr, 6'd0);
        chk_d("mid_data0", bus.mem_wr_data, 2'd1);
        tick();
        chk_a("mid_addr1", bus.mem_wr_addr, 6'd1);
        chk_d("mid_data1", bus.mem_wr_data, 2'd2);
        bus.start     = 1'b1;
        bus.append    = 1'b1;
        bus.seed_load = 1'b1;
        bus.seed      = 8'h55;
        tick();
        idle_inputs();
        chk_b("mid_wr_en2", bus.mem_wr_en, 1'b1);
        chk_a("mid_addr2", bus.mem_wr_addr, 6'd2);
        chk_d("mid_data2", bus.mem_wr_data, 2'd0);
        tick();
        chk_a("mid_addr3", bus.mem_wr_addr, 6'd3);
        chk_d("mid_data3", bus.mem_wr_data, 2'd0);
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.done) done_cnt++;
            chk_b("mid_no_write", bus.mem_wr_en, 1'b0);
        end
        chk_a("mid_done_count", AW'(done_cnt), 6'd1);
        chk_a("mid_seq_len", bus.seq_len, 6'd4);
        do_append("mid_app", 6'd4, 2'd1);

        // Reset in FILL cycle 2 abandons the fill.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk_a("rstf_addr1", bus.mem_wr_addr, 6'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_b("rstf_wr_en", bus.mem_wr_en, 1'b0);
        chk_a("rstf_seq_len", bus.seq_len, 6'd0);
        chk_b("rstf_busy", bus.busy, 1'b0);
        chk_b("rstf_done", bus.done, 1'b0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        run_fill("rstf_fill", {2'd0, 2'd0, 2'd2, 2'd1});

        // start + append together: fill only (lfsr 11,23,47,8E -> 1,3,3,2).
        bus.start  = 1'b1;
        bus.append = 1'b1;
        tick();
        idle_inputs();
        run_fill("both_fill", {2'd2, 2'd3, 2'd3, 2'd1});
        tick();
        chk_b("both_no_append", bus.mem_wr_en, 1'b0);
        chk_a("both_seq_len", bus.seq_len, 6'd4);

        // seed_load + start: seed loaded, start dropped (5A,B4,69,D2 -> 2,0,1,2).
        bus.seed_load = 1'b1;
        bus.seed      = 8'h5A;
        bus.start     = 1'b1;
        tick();
        idle_inputs();
        chk_b("ss_wr_en", bus.mem_wr_en, 1'b0);
        chk_b("ss_busy", bus.busy, 1'b0);
        tick();
        chk_b("ss_wr_en2", bus.mem_wr_en, 1'b0);
        chk_b("ss_done", bus.done, 1'b0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        run_fill("ss_fill", {2'd2, 2'd1, 2'd0, 2'd2});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
